udma_i2s_tx_serializer: RTL

UDMA_I2S_TX_SERIALIZER -- requirements
Module: udma_i2s_tx_serializer

---
 rtl/udma_i2s_tx_serializer_if.sv | 13 +
 rtl/udma_i2s_tx_serializer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/udma_i2s_tx_serializer_if.sv
// Sample stream carrying TX words from the FIFO into the I2S serializer.
//   data_i  : 32-bit sample word, valid while valid_i is high
//   valid_i : producer has a word available
//   ready_o : serializer accepts the word this cycle
// A word moves across when valid_i and ready_o are both high at a clock edge.
interface udma_i2s_tx_serializer_if;
   logic [31:0] data_i;
   logic        valid_i;
   logic        ready_o;

   modport master (output data_i, output valid_i, input ready_o);
   modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/udma_i2s_tx_serializer.sv
// I2S master transmit serializer.
// Pulls sample words from a valid/ready stream and shifts them out on SD
// while generating SCK and WS, with a programmable SCK divider, word
// length and bit order.
//   clk_i, rst_i      : peripheral clock, synchronous active-high reset
//   cfg_en_i          : serializer enable, dropping it returns to IDLE
//   cfg_div_i         : SCK half-period minus 1, in clk_i cycles
//   cfg_bits_word_i   : bits per word minus 1 (0 is treated as 1)
//   cfg_lsb_first_i   : 1 = LSB first, 0 = MSB first
//   stream            : data_i / valid_i / ready_o sample stream
//   sck_o, sck_oe     : bit clock and its output enable
//   ws_o, ws_oe       : word select and its output enable
//   sd_o              : serial data
//   underrun_o        : one-cycle pulse when a word was due but none was ready
module udma_i2s_tx_serializer #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cfg_en_i,
   input  logic [DIV_WIDTH-1:0] cfg_div_i,
   input  logic [4:0]           cfg_bits_word_i,
   input  logic                 cfg_lsb_first_i,
   udma_i2s_tx_serializer_if.slave stream,
   output logic                 sck_o,
   output logic                 sck_oe,
   output logic                 ws_o,
   output logic                 ws_oe,
   output logic                 sd_o,
   output logic                 underrun_o
);

   typedef enum logic [1:0] {IDLE, START, RUN} state_t;

   state_t               state_q;
   logic [DIV_WIDTH-1:0] div_cnt_q;
   logic [4:0]           bit_cnt_q;
   logic [4:0]           bits_q;
   logic                 lsb_q;
   logic [31:0]          shift_q;
   logic                 sck_q;
   logic                 ws_q;
   logic                 oe_q;
   logic                 underrun_q;

   logic [4:0]           bits_eff;
   logic [31:0]          load_word;
   logic                 div_hit;
   logic                 fall;
   logic                 boundary;
   logic                 ready;

   // Word setup and SCK event decode. MSB-first words are left-justified so
   // the first bit always sits in bit 31 and unused upper data bits fall off.
   // ready is combinational so a word can be taken in the very boundary cycle;
   // enable and reset both veto it so no word is lost on shutdown.
   always_comb begin
      bits_eff  = (cfg_bits_word_i == 5'd0) ? 5'd1 : cfg_bits_word_i;
      load_word = cfg_lsb_first_i ? stream.data_i
                                  : (stream.data_i << (5'd31 - bits_eff));
      div_hit   = (state_q == RUN) && (div_cnt_q == cfg_div_i);
      fall      = div_hit && sck_q;
      boundary  = fall && (bit_cnt_q == bits_q);
      ready     = !rst_i && cfg_en_i && ((state_q == START) || boundary);
   end

   // Main FSM. The divider compares against the live cfg_div_i, so lowering
   // it below the running count lets the counter wrap around silently. WS is
   // flipped one bit early, when the last bit of a word is driven, so it
   // leads the next word by one SCK period. A boundary without data loads
   // zeros and keeps the frame timing intact.
   always_ff @(posedge clk_i) begin
      if (rst_i || !cfg_en_i) begin
         state_q    <= IDLE;
         div_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         bits_q     <= '0;
         lsb_q      <= 1'b0;
         shift_q    <= '0;
         sck_q      <= 1'b0;
         ws_q       <= 1'b0;
         oe_q       <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         underrun_q <= 1'b0;
         case (state_q)
            IDLE: begin
               state_q <= START;
            end
            START: begin
               if (stream.valid_i && ready) begin
                  shift_q   <= load_word;
                  bits_q    <= bits_eff;
                  lsb_q     <= cfg_lsb_first_i;
                  ws_q      <= 1'b0;
                  bit_cnt_q <= '0;
                  div_cnt_q <= '0;
                  oe_q      <= 1'b1;
                  state_q   <= RUN;
               end
            end
            RUN: begin
               if (div_hit) begin
                  div_cnt_q <= '0;
                  sck_q     <= ~sck_q;
               end else begin
                  div_cnt_q <= div_cnt_q + 1'b1;
               end
               if (fall) begin
                  if (boundary) begin
                     shift_q    <= stream.valid_i ? load_word : 32'd0;
                     bits_q     <= bits_eff;
                     lsb_q      <= cfg_lsb_first_i;
                     bit_cnt_q  <= '0;
                     underrun_q <= !stream.valid_i;
                  end else begin
                     shift_q   <= lsb_q ? (shift_q >> 1) : (shift_q << 1);
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                     if ((bit_cnt_q + 5'd1) == bits_q) begin
                        ws_q <= ~ws_q;
                     end
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign stream.ready_o = ready;
   assign sck_o          = sck_q;
   assign sck_oe         = oe_q;
   assign ws_o           = ws_q;
   assign ws_oe          = oe_q;
   assign sd_o           = lsb_q ? shift_q[0] : shift_q[31];
   assign underrun_o     = underrun_q;

endmodule
